bht_update_sched: RTL and testbench

- Scheduler that sequences all writes into the branch history table (BHT).
- Queues conditional-branch outcomes retired by the ROB and drains them to the BHT pattern-update port, one per cycle.
- Sequences BHR recovery on an exception and gates fetch-stage prediction until the queued updates are applied.
- Sits between the ROB retire outputs and the BHT; the BHT sees only pre-hashed update indices from this block.

---
 rtl/bht_update_sched.sv | 133 +++++++++++++
 tb/tb_bht_update_sched.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_sched.sv
// BHT write scheduler: queues retired conditional-branch outcomes, drains them to the
// BHT update port and sequences BHR recovery. Optional BHT_DUAL_DRAIN_EN adds a second drain lane.
module bht_update_sched #(
  parameter int BIT_BHT = 6,
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rob_retire_cond0,
  input  logic [63:0]        rob_retire_NPC0,
  input  logic [BIT_BHT-1:0] rob_retire_BHR0,
  input  logic               rob_actual_taken0,
  input  logic               rob_retire_cond1,
  input  logic [63:0]        rob_retire_NPC1,
  input  logic [BIT_BHT-1:0] rob_retire_BHR1,
  input  logic               rob_actual_taken1,
  input  logic               recover_cond,
  input  logic [BIT_BHT-1:0] recover_bhr,
  input  logic               bht_upd_ready,
  output logic               bht_upd_valid,
  output logic [BIT_BHT-1:0] bht_upd_idx,
  output logic               bht_upd_taken,
`ifdef BHT_DUAL_DRAIN_EN
  output logic               bht_upd_valid1,
  output logic [BIT_BHT-1:0] bht_upd_idx1,
  output logic               bht_upd_taken1,
`endif
  output logic               bht_recover,
  output logic [BIT_BHT-1:0] bht_recover_bhr,
  output logic               if_pred_en,
  output logic               rob_retire_stall,
  output logic               overflow_err
);
  localparam int E_W = BIT_BHT + 1;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RECOVER = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [E_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [1:0]         state_q, state_d;
  logic [BIT_BHT-1:0] rbhr_q, rbhr_d;
  logic               ovf_q, ovf_d;

  logic [PTR_W+1:0]   space;
  logic [1:0]         enq_n, deq_n;
  logic               acc0, acc1;
  logic [E_W-1:0]     ent0, ent1;

  function automatic logic [BIT_BHT-1:0] hash_idx(input logic [BIT_BHT-1:0] npc_bits,
                                                  input logic [BIT_BHT-1:0] bhr);
    return npc_bits ^ bhr;
  endfunction

  logic unused_npc_bits;
  assign unused_npc_bits = ^{rob_retire_NPC0[63:BIT_BHT+2], rob_retire_NPC0[1:0],
                             rob_retire_NPC1[63:BIT_BHT+2], rob_retire_NPC1[1:0]};

  assign ent0 = {hash_idx(rob_retire_NPC0[BIT_BHT+1:2], rob_retire_BHR0), rob_actual_taken0};
  assign ent1 = {hash_idx(rob_retire_NPC1[BIT_BHT+1:2], rob_retire_BHR1), rob_actual_taken1};

  assign bht_upd_valid = (count_q != '0);
  assign {bht_upd_idx, bht_upd_taken} = mem_q[head_q];

`ifdef BHT_DUAL_DRAIN_EN
  assign {bht_upd_idx1, bht_upd_taken1} = mem_q[head_q + PTR_W'(1)];
  // Same-index pairs go one at a time so the counter sees both increments.
  assign bht_upd_valid1 = (count_q >= (PTR_W+1)'(2)) && (bht_upd_idx1 != bht_upd_idx);
  assign deq_n = !bht_upd_ready ? 2'd0 : bht_upd_valid1 ? 2'd2 : bht_upd_valid ? 2'd1 : 2'd0;
`else
  assign deq_n = (bht_upd_valid && bht_upd_ready) ? 2'd1 : 2'd0;
`endif

  // Slots freed by this cycle's pop count as space; slot 1 is the first to be dropped.
  always_comb begin
    space = (PTR_W+2)'(DEPTH) - {1'b0, count_q} + {{PTR_W{1'b0}}, deq_n};
    acc0  = rob_retire_cond0 && (space != '0);
    acc1  = rob_retire_cond1 && (space > {{(PTR_W+1){1'b0}}, acc0});
    enq_n = {1'b0, acc0} + {1'b0, acc1};
  end

  always_comb begin
    head_d  = head_q + PTR_W'(deq_n);
    tail_d  = tail_q + PTR_W'(enq_n);
    count_d = count_q + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_n);
    ovf_d   = ovf_q | (rob_retire_cond0 & ~acc0) | (rob_retire_cond1 & ~acc1);
  end

  always_comb begin
    state_d = state_q;
    rbhr_d  = rbhr_q;
    case (state_q)
      S_IDLE:    if (recover_cond) begin state_d = S_RECOVER; rbhr_d = recover_bhr; end
      S_RECOVER: if (recover_cond) rbhr_d = recover_bhr;
                 else              state_d = S_DRAIN;
      S_DRAIN:   if (recover_cond) begin state_d = S_RECOVER; rbhr_d = recover_bhr; end
                 else if (count_q == '0) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      rbhr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      rbhr_q  <= rbhr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (acc0) mem_q[tail_q] <= ent0;
    if (acc1) mem_q[acc0 ? tail_q + PTR_W'(1) : tail_q] <= ent1;
  end

  assign bht_recover      = (state_q == S_RECOVER);
  assign bht_recover_bhr  = rbhr_q;
  assign if_pred_en       = (state_q == S_IDLE) && !recover_cond;
  assign rob_retire_stall = (count_q > (PTR_W+1)'(DEPTH-2));
  assign overflow_err     = ovf_q;
endmodule

// File: tb/tb_bht_update_sched.sv
// Scoreboard bench for bht_update_sched: expected updates queued at retire, checked at drain.
module tb_bht_update_sched;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        c0 = 0, t0 = 0, c1 = 0, t1 = 0;
  logic [63:0] n0 = '0, n1 = '0;
  logic [5:0]  b0 = '0, b1 = '0;
  logic        recover_cond = 0;
  logic [5:0]  recover_bhr = '0;
  logic        rdy = 0;
  logic        bht_upd_valid, bht_upd_taken, bht_recover, if_pred_en, rob_retire_stall, overflow_err;
  logic [5:0]  bht_upd_idx, bht_recover_bhr;
`ifdef BHT_DUAL_DRAIN_EN
  logic        bht_upd_valid1, bht_upd_taken1;
  logic [5:0]  bht_upd_idx1;
`endif

  int checks = 0;
  int errors = 0;
  logic [6:0] sbq[$];

  always #5 clock = ~clock;

  bht_update_sched #(.BIT_BHT(6), .DEPTH(8), .PTR_W(3)) dut (
    .clock(clock), .reset(reset),
    .rob_retire_cond0(c0), .rob_retire_NPC0(n0), .rob_retire_BHR0(b0), .rob_actual_taken0(t0),
    .rob_retire_cond1(c1), .rob_retire_NPC1(n1), .rob_retire_BHR1(b1), .rob_actual_taken1(t1),
    .recover_cond(recover_cond), .recover_bhr(recover_bhr), .bht_upd_ready(rdy),
    .bht_upd_valid(bht_upd_valid), .bht_upd_idx(bht_upd_idx), .bht_upd_taken(bht_upd_taken),
`ifdef BHT_DUAL_DRAIN_EN
    .bht_upd_valid1(bht_upd_valid1), .bht_upd_idx1(bht_upd_idx1), .bht_upd_taken1(bht_upd_taken1),
`endif
    .bht_recover(bht_recover), .bht_recover_bhr(bht_recover_bhr), .if_pred_en(if_pred_en),
    .rob_retire_stall(rob_retire_stall), .overflow_err(overflow_err)
  );

  // Scoreboard monitor: presence of a head entry and the popped contents.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (bht_upd_valid !== (sbq.size() != 0)) begin
        errors++;
        $display("FAIL sb_valid: got %b expected %b (queued %0d)", bht_upd_valid, sbq.size() != 0, sbq.size());
      end
      if (bht_upd_valid === 1'b1 && rdy && sbq.size() != 0) begin
        logic [6:0] exp_e;
        exp_e = sbq.pop_front();
        checks++;
        if ({bht_upd_idx, bht_upd_taken} !== exp_e) begin
          errors++;
          $display("FAIL sb_entry: got idx=%b taken=%b expected idx=%b taken=%b",
                   bht_upd_idx, bht_upd_taken, exp_e[6:1], exp_e[0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic logic [6:0] mk(input logic [63:0] npc, input logic [5:0] bhr, input logic tk);
    logic [5:0] pc_bits;
    pc_bits = npc[7:2];
    return {pc_bits ^ bhr, tk};
  endfunction

  // Drives one retire cycle; accepted entries enter the scoreboard once the DUT has latched them.
  task automatic retire(input logic a_c0, input logic [63:0] a_n0, input logic [5:0] a_b0, input logic a_t0,
                        input logic a_c1, input logic [63:0] a_n1, input logic [5:0] a_b1, input logic a_t1);
    int space;
    logic k0, k1;
    space = 8 - sbq.size() + ((sbq.size() != 0 && rdy) ? 1 : 0);
    k0 = a_c0 && space > 0;
    k1 = a_c1 && space > (k0 ? 1 : 0);
    c0 = a_c0; n0 = a_n0; b0 = a_b0; t0 = a_t0;
    c1 = a_c1; n1 = a_n1; b1 = a_b1; t1 = a_t1;
    @(posedge clock);
    if (k0) sbq.push_back(mk(a_n0, a_b0, a_t0));
    if (k1) sbq.push_back(mk(a_n1, a_b1, a_t1));
    #1;
    c0 = 0; c1 = 0;
  endtask

  task automatic do_reset();
    reset = 1; rdy = 0; c0 = 0; c1 = 0; recover_cond = 0;
    sbq.delete();
    tick();
    reset = 0;
    @(negedge clock);
    checks++;
    if ({bht_upd_valid, bht_recover, bht_recover_bhr, if_pred_en, rob_retire_stall, overflow_err} !== {1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got valid=%b rec=%b rbhr=%b pred=%b stall=%b ovf=%b expected 0 0 000000 1 0 0",
               bht_upd_valid, bht_recover, bht_recover_bhr, if_pred_en, rob_retire_stall, overflow_err);
    end
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    do_reset();
  endtask

  task automatic test_single();
    rdy = 1;
    retire(1, 64'h1008, 6'b000011, 1, 0, '0, '0, 0);
    @(negedge clock);
    checks++;
    if ({bht_upd_valid, bht_upd_idx, bht_upd_taken} !== {1'b1, 6'b000001, 1'b1}) begin
      errors++;
      $display("FAIL single_head: got v=%b idx=%b t=%b expected 1 000001 1", bht_upd_valid, bht_upd_idx, bht_upd_taken);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bht_upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: got valid=%b expected 0", bht_upd_valid);
    end
    tick();
    rdy = 0;
  endtask

  task automatic test_dual_retire();
    rdy = 0;
    retire(1, 64'h1000, 6'd0, 1, 1, 64'h1004, 6'd0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if ({bht_upd_valid, bht_upd_idx} !== {1'b1, 6'd0}) begin
        errors++;
        $display("FAIL dual_hold%0d: got v=%b idx=%b expected 1 000000", i, bht_upd_valid, bht_upd_idx);
      end
      tick();
    end
    rdy = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if ({bht_upd_valid, bht_upd_idx, bht_upd_taken} !== {1'b1, 6'(i), (i == 0)}) begin
        errors++;
        $display("FAIL dual_order%0d: got v=%b idx=%b t=%b expected 1 %b %b", i, bht_upd_valid, bht_upd_idx,
                 bht_upd_taken, 6'(i), (i == 0));
      end
      tick();
    end
    @(negedge clock);
    checks++;
    if (bht_upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL dual_empty: got valid=%b expected 0", bht_upd_valid);
    end
    tick();
    rdy = 0;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 3; i++)
      retire(1, 64'h2000 + 64'(16 * i), 6'(i), 1, 1, 64'h2004 + 64'(16 * i), 6'(i), 0);
    @(negedge clock);
    checks++;
    if (rob_retire_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_at6: got %b expected 0", rob_retire_stall);
    end
    tick();
    retire(1, 64'h2100, 6'b110000, 0, 0, '0, '0, 0);
    @(negedge clock);
    checks++;
    if ({rob_retire_stall, overflow_err} !== 2'b10) begin
      errors++;
      $display("FAIL stall_at7: got stall=%b ovf=%b expected 1 0", rob_retire_stall, overflow_err);
    end
    tick();
    retire(1, 64'h3000, 6'b001100, 1, 1, 64'h3004, 6'b111111, 0);
    @(negedge clock);
    checks++;
    if ({rob_retire_stall, overflow_err} !== 2'b11) begin
      errors++;
      $display("FAIL overflow_set: got stall=%b ovf=%b expected 1 1", rob_retire_stall, overflow_err);
    end
    tick();
    rdy = 1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
    tick();
    @(negedge clock);
    checks++;
    if (sbq.size() != 0 || overflow_err !== 1'b1 || bht_upd_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_sticky: got ovf=%b valid=%b left=%0d expected 1 0 0", overflow_err, bht_upd_valid, sbq.size());
    end
    tick();
    rdy = 0;
  endtask

  task automatic test_recover();
    do_reset();
    retire(1, 64'h4000, 6'b000001, 1, 1, 64'h4004, 6'b000010, 1);
    retire(1, 64'h4008, 6'b000100, 0, 0, '0, '0, 0);
    recover_cond = 1; recover_bhr = 6'b101010;
    @(negedge clock);
    checks++;
    if ({if_pred_en, bht_recover} !== 2'b00) begin
      errors++;
      $display("FAIL rec_cycle: got pred=%b rec=%b expected 0 0", if_pred_en, bht_recover);
    end
    tick();
    recover_cond = 0;
    @(negedge clock);
    checks++;
    if ({bht_recover, bht_recover_bhr, if_pred_en} !== {1'b1, 6'b101010, 1'b0}) begin
      errors++;
      $display("FAIL rec_pulse: got rec=%b bhr=%b pred=%b expected 1 101010 0", bht_recover, bht_recover_bhr, if_pred_en);
    end
    tick();
    @(negedge clock);
    checks++;
    if ({bht_recover, if_pred_en} !== 2'b00) begin
      errors++;
      $display("FAIL rec_once: got rec=%b pred=%b expected 0 0", bht_recover, if_pred_en);
    end
    tick();
  endtask

  task automatic test_rerecover();
    logic [6:0] head_e;
    head_e = sbq[0];
    recover_cond = 1; recover_bhr = 6'b000111;
    tick();
    recover_cond = 0;
    @(negedge clock);
    checks++;
    if ({bht_recover, bht_recover_bhr, bht_upd_valid, bht_upd_idx, bht_upd_taken} !== {1'b1, 6'b000111, 1'b1, head_e}) begin
      errors++;
      $display("FAIL rerec_pulse: got rec=%b bhr=%b v=%b head=%b%b expected 1 000111 1 %b", bht_recover,
               bht_recover_bhr, bht_upd_valid, bht_upd_idx, bht_upd_taken, head_e);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bht_recover !== 1'b0) begin
      errors++;
      $display("FAIL rerec_once: got rec=%b expected 0", bht_recover);
    end
    tick();
    rdy = 1;
    begin
      int n;
      n = 0;
      @(negedge clock);
      while (bht_upd_valid === 1'b1 && n < 20) begin
        checks++;
        if (if_pred_en !== 1'b0) begin
          errors++;
          $display("FAIL drain_gate: got pred=%b expected 0 while entries queued", if_pred_en);
        end
        n++;
        tick();
        @(negedge clock);
      end
      if (n >= 20) begin
        errors++;
        $display("FAIL drain_timeout: queue did not empty within 20 cycles");
      end
    end
    tick();
    @(negedge clock);
    checks++;
    if (if_pred_en !== 1'b1) begin
      errors++;
      $display("FAIL drain_release: got pred=%b expected 1", if_pred_en);
    end
    tick();
    rdy = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    retire(1, 64'h5000, 6'd1, 1, 1, 64'h5004, 6'd2, 0);
    retire(1, 64'h5008, 6'd3, 1, 1, 64'h500c, 6'd4, 0);
    retire(1, 64'h5010, 6'd5, 1, 0, '0, '0, 0);
    recover_cond = 1; recover_bhr = 6'b110011;
    tick();
    recover_cond = 0;
    tick();
    @(negedge clock);
    checks++;
    if ({if_pred_en, bht_upd_valid} !== 2'b01) begin
      errors++;
      $display("FAIL mid_setup: got pred=%b valid=%b expected 0 1", if_pred_en, bht_upd_valid);
    end
    tick();
    do_reset();
    @(negedge clock);
    checks++;
    if ({if_pred_en, bht_upd_valid, bht_recover} !== 3'b100) begin
      errors++;
      $display("FAIL mid_after: got pred=%b valid=%b rec=%b expected 1 0 0", if_pred_en, bht_upd_valid, bht_recover);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual_retire();
    test_full();
    test_recover();
    test_rerecover();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
